adder_nibble_seq: RTL and testbench

- Multi-cycle controller that sequences a single 4-bit ripple adder (adder4b) to add or subtract two W-bit operands, one nibble per clock, LSB nibble first.
- Carry is chained through a registered carry bit.
- Provides a start/busy/done handshake.
- Sits between a register-file/ALU front end and the shared 4-bit adder datapath, trading latency for area.

---
 rtl/adder_seq_pkg.sv | 13 +
 rtl/adder4b.sv | 23 ++
 rtl/adder_nibble_seq.sv | 119 +++++++++++
 tb/tb_adder_nibble_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller.
// The state encoding is fixed so that it stays stable for anyone probing the state register.
package adder_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder4b.sv
// 4-bit ripple-carry adder slice. This is the single shared datapath that the sequencer time-multiplexes.
module adder4b (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Ci,
   output logic [3:0] S,
   output logic       Co
);

   logic [4:0] c;

   always_comb begin
      c    = '0;
      S    = '0;
      c[0] = Ci;
      for (int i = 0; i < 4; i++) begin
         S[i]   = A[i] ^ B[i] ^ c[i];
         c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
      Co = c[4];
   end

endmodule

// File: rtl/adder_nibble_seq.sv
// Sequences one 4-bit adder over W-bit operands, LSB nibble first, with a start/busy/done handshake.
// Subtraction adds the inverted B with the carry seeded to 1.
module adder_nibble_seq
   import adder_seq_pkg::*;
#(
   parameter int N_NIBBLES = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            sub,
   input  logic [NIBBLE_W*N_NIBBLES-1:0]   a,
   input  logic [NIBBLE_W*N_NIBBLES-1:0]   b,
   output logic                            busy,
   output logic                            done,
   output logic [NIBBLE_W*N_NIBBLES-1:0]   result,
   output logic                            cout,
   output logic                            ovf
);

   localparam int W     = NIBBLE_W * N_NIBBLES;
   localparam int CNT_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 carry;
   logic [W-1:0]         a_lat;
   logic [W-1:0]         b_eff;
   logic [W-1:0]         acc;
   logic [W-1:0]         acc_nxt;
   logic [NIBBLE_W-1:0]  nib_a;
   logic [NIBBLE_W-1:0]  nib_b;
   logic [NIBBLE_W-1:0]  nib_s;
   logic                 nib_co;
   logic                 last;

   assign last = (cnt == CNT_W'(N_NIBBLES - 1));
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Select the active nibble and splice the adder sum back into the partial result.
   always_comb begin
      nib_a   = '0;
      nib_b   = '0;
      acc_nxt = acc;
      for (int i = 0; i < N_NIBBLES; i++) begin
         if (cnt == CNT_W'(i)) begin
            nib_a                            = a_lat[i*NIBBLE_W +: NIBBLE_W];
            nib_b                            = b_eff[i*NIBBLE_W +: NIBBLE_W];
            acc_nxt[i*NIBBLE_W +: NIBBLE_W]  = nib_s;
         end
      end
   end

   adder4b u_adder (
      .A  (nib_a),
      .B  (nib_b),
      .Ci (carry),
      .S  (nib_s),
      .Co (nib_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         carry  <= 1'b0;
         a_lat  <= '0;
         b_eff  <= '0;
         acc    <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat <= a;
                  b_eff <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               acc   <= acc_nxt;
               carry <= nib_co;
               cnt   <= cnt + CNT_W'(1);
               // Publish only the complete word so partial nibbles never reach the outputs.
               if (last) begin
                  result <= acc_nxt;
                  cout   <= nib_co;
                  ovf    <= (a_lat[W-1] == b_eff[W-1]) && (acc_nxt[W-1] != a_lat[W-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Scoreboard bench for adder_nibble_seq with 16-bit operands (four nibbles).
module tb_adder_nibble_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   adder_nibble_seq #(.N_NIBBLES(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   s;
      be    = ts ? ~tb_v : tb_v;
      s     = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ts};
      e.res = s[W-1:0];
      e.co  = s[W];
      e.ov  = (ta[W-1] == be[W-1]) && (s[W-1] != ta[W-1]);
      return e;
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("cout", 32'(cout), 32'(e.co));
            check("ovf", 32'(ovf), 32'(e.ov));
         end
      end
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
      @(negedge clk);
      a     = ta;
      b     = tb_v;
      sub   = ts;
      start = 1'b1;
      sb.push_back(model(ta, tb_v, ts));
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= N + 1; i++) begin
         @(negedge clk);
         check("busy_run", 32'(busy), 32'd1);
         check("done_timing", 32'(done), 32'(i == N + 1));
      end
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
      check("done_after", 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      int since;

      // Reset with random inputs
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'h0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_result", 32'(result), 32'h0);

      // Arithmetic cases
      run_op(16'h1234, 16'h0FF0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0);
      repeat (5) @(negedge clk);
      check("hold_result", 32'(result), 32'h8000);
      check("hold_ovf", 32'(ovf), 32'd1);
      run_op(16'h8000, 16'h0001, 1'b1);
      run_op(16'h0003, 16'h0005, 1'b1);
      for (int k = 0; k < 4; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom);
         run_op(ra, rb, 1'(k));
      end

      // Back-to-back with start held high; operands disturbed mid-RUN of the second op
      @(negedge clk);
      a     = 16'h0001;
      b     = 16'h0001;
      sub   = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back(model(16'h0001, 16'h0001, 1'b0));
      ndone = 0;
      since = 0;
      for (int c = 0; c < 40 && ndone < 3; c++) begin
         @(negedge clk);
         since++;
         if (ndone == 1 && since == 3) begin
            a = 16'h00FF;
            b = 16'h0100;
         end
         if (ndone == 1 && since == 5) begin
            a = 16'h0001;
            b = 16'h0001;
         end
         if (done) begin
            if (ndone > 0) check("b2b_gap", 32'(since), 32'd6);
            since = 0;
            ndone++;
            if (ndone == 3) start = 1'b0;
         end
      end
      check("b2b_count", 32'(ndone), 32'd3);
      repeat (3) @(negedge clk);
      check("b2b_idle", 32'(busy), 32'd0);

      // Reset two cycles after accept
      @(negedge clk);
      a     = 16'h5555;
      b     = 16'h1111;
      start = 1'b1;
      sb.push_back(model(16'h5555, 16'h1111, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'h0);
      check("midrst_cout", 32'(cout), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_idle", 32'(busy), 32'd0);
      run_op(16'h0010, 16'h0020, 1'b0);

      repeat (4) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
